// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity types
// and the legal parameter ranges of the frame checker.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    // Count events, stick at all-ones, clear synchronously on request.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_inc && (o_cnt != {W{1'b1}}))
            o_cnt <= o_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_frame_check.sv
// UART receive frame checker: walks start/data/parity/stop positions on each
// decided bit, deserialises the word, flags glitch/parity/stop errors and
// keeps saturating counts of each error type.
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 frame_start,
    input  logic                 bit_vld,
    input  logic                 sampled_bit,
    input  logic                 par_en,
    input  logic                 par_typ,
    input  logic                 clr_cnt,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_vld,
    output logic                 strt_glitch,
    output logic                 par_err,
    output logic                 stp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] glitch_cnt,
    output logic [ERR_CNT_W-1:0] par_err_cnt,
    output logic [ERR_CNT_W-1:0] stp_err_cnt
);

    localparam int IDX_W = $clog2(DATA_W);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_bit_idx, w_bit_idx_nxt;
    logic [DATA_W-1:0]  r_shift, w_shift_nxt;
    logic               r_stop_idx, w_stop_idx_nxt;
    logic               r_par_fail, w_par_fail_nxt;
    logic               r_stp_fail, w_stp_fail_nxt;
    logic               r_par_en, r_par_typ;
    logic               w_latch;
    logic               w_stp_any;
    logic               w_glitch, w_par_ev, w_stp_ev, w_good;

    // Next-state and per-frame event decode; every non-IDLE move waits on bit_vld.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_stop_idx_nxt = r_stop_idx;
        w_par_fail_nxt = r_par_fail;
        w_stp_fail_nxt = r_stp_fail;
        w_latch        = 1'b0;
        w_stp_any      = r_stp_fail | ~sampled_bit;
        w_glitch       = 1'b0;
        w_par_ev       = 1'b0;
        w_stp_ev       = 1'b0;
        w_good         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A bit strobe coincident with frame_start belongs to no frame.
                if (frame_start) begin
                    w_state_nxt    = ST_START;
                    w_latch        = 1'b1;
                    w_par_fail_nxt = 1'b0;
                    w_stp_fail_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (bit_vld) begin
                    if (sampled_bit) begin
                        w_glitch    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_vld) begin
                    w_shift_nxt = {sampled_bit, r_shift[DATA_W-1:1]};
                    if (r_bit_idx == IDX_W'(DATA_W-1)) begin
                        w_state_nxt    = r_par_en ? ST_PARITY : ST_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_vld) begin
                    if (sampled_bit != (^r_shift ^ r_par_typ))
                        w_par_fail_nxt = 1'b1;
                    w_state_nxt    = ST_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_vld) begin
                    if (r_stop_idx == 1'(STOP_BITS-1)) begin
                        w_par_ev       = r_par_fail;
                        w_stp_ev       = w_stp_any;
                        w_good         = !r_par_fail && !w_stp_any;
                        w_par_fail_nxt = 1'b0;
                        w_stp_fail_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_stp_fail_nxt = w_stp_any;
                        w_stop_idx_nxt = r_stop_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM and frame-tracking registers; reset drops any partial frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_stop_idx <= 1'b0;
            r_par_fail <= 1'b0;
            r_stp_fail <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_par_fail <= w_par_fail_nxt;
            r_stp_fail <= w_stp_fail_nxt;
            if (w_latch) begin
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
            end
        end
    end

    // Registered outputs: one-cycle event pulses, held data word, busy flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_out    <= '0;
            data_vld    <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (w_good)
                data_out <= r_shift;
            data_vld    <= w_good;
            strt_glitch <= w_glitch;
            par_err     <= w_par_ev;
            stp_err     <= w_stp_ev;
            busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_glitch_cnt (
        .Clk(Clk), .Rst(Rst), .i_inc(w_glitch), .i_clr(clr_cnt), .o_cnt(glitch_cnt)
    );
    sat_counter #(.W(ERR_CNT_W)) u_par_cnt (
        .Clk(Clk), .Rst(Rst), .i_inc(w_par_ev), .i_clr(clr_cnt), .o_cnt(par_err_cnt)
    );
    sat_counter #(.W(ERR_CNT_W)) u_stp_cnt (
        .Clk(Clk), .Rst(Rst), .i_inc(w_stp_ev), .i_clr(clr_cnt), .o_cnt(stp_err_cnt)
    );

endmodule

// File: doc/uart_frame_check.md
Name: uart_frame_check

Overview:
Parametrised UART receive frame checker that supersedes the single-bit start-glitch checker. It consumes oversampler-decided bits and tracks frame position itself. Per frame it performs start-glitch, parity and stop-bit checks, deserialises the data word, and keeps saturating per-error statistics counters. It sits between the bit sampler/edge detector and the RX output register stage.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9), LSB first on the line
STOP_BITS, 1, stop bits checked per frame (legal 1 or 2)
ERR_CNT_W, 8, width of each saturating error counter

Ports:
Clk  input  1  clock
Rst  input  1  reset, asynchronous, active-low
frame_start  input  1  one-cycle pulse from the edge detector on a line falling edge
bit_vld  input  1  one-cycle strobe; sampled_bit holds a decided bit this cycle
sampled_bit  input  1  majority-voted line bit
par_en  input  1  parity bit present; latched at frame start
par_typ  input  1  0 = even, 1 = odd; latched at frame start
clr_cnt  input  1  synchronous clear of all error counters
data_out  output  DATA_W  last good frame data; held between frames
data_vld  output  1  one-cycle pulse: good frame on data_out
strt_glitch  output  1  one-cycle pulse: start bit sampled high
par_err  output  1  one-cycle pulse: parity mismatch
stp_err  output  1  one-cycle pulse: any stop bit sampled low
busy  output  1  high whenever FSM is not IDLE
glitch_cnt, par_err_cnt, stp_err_cnt  output  ERR_CNT_W each  saturating event counts

Behaviour:
- Reset: all outputs 0, FSM = IDLE, bit index 0, shift register 0. Reset mid-frame drops the frame silently; no pulses are generated.
- All outputs are registered. Pulses assert in the cycle after the clock edge that consumes the deciding bit_vld and last exactly one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every transition out of a non-IDLE state happens only on bit_vld.
- IDLE: on frame_start, latch par_en/par_typ and go to START. bit_vld in IDLE is ignored. If frame_start and bit_vld occur in the same IDLE cycle, go to START and do not consume that bit.
- START: if sampled_bit = 1, pulse strt_glitch, increment glitch_cnt, return to IDLE. If sampled_bit = 0, go to DATA with bit_idx = 0.
- DATA: shift sampled_bit into the MSB, shifting right (LSB first). At bit_idx = DATA_W-1, go to PARITY if latched par_en, else STOP. Otherwise increment bit_idx.
- PARITY: expected bit = XOR(data) XOR par_typ. On mismatch, set the internal par_fail flag. Go to STOP.
- STOP: check STOP_BITS bits. Any 0 sets the internal stp_fail flag. After the final stop bit:
  - Pulse par_err if par_fail; pulse stp_err if stp_fail; increment the corresponding counters.
  - If neither flag is set, load data_out and pulse data_vld.
  - Clear both flags and return to IDLE.
  - data_out is unchanged on an errored frame.
- frame_start while busy is ignored.
- par_en/par_typ changes mid-frame have no effect until the next frame_start.
- Counters: increment by 1 per event and saturate at all-ones with no wrap. clr_cnt has priority over a same-cycle increment (result 0).
- Worst-case frame: 1 + DATA_W + 1 + STOP_BITS bit_vld strobes.

Decomposition:
- Shared package uart_rx_pkg holds:
  - FSM state encoding typedef (3-bit)
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1
  - legal range constants for DATA_W and STOP_BITS
- One natural sub-module: sat_counter (parameter W, inputs inc/clr), instantiated three times for the error counters.

Test Plan:
1. DATA_W=8, par_en=0, frame_start then bits 0,1,0,1,0,0,1,0,1,1 (data 0xA5, stop 1) -> data_vld pulse, data_out=0xA5, no error pulses, busy low after the pulse.
2. par_en=1, par_typ=0, data 0xA5, parity bit 0, stop 1 -> data_vld, data_out=0xA5. Same frame with parity bit 1 -> par_err pulse, par_err_cnt=1, data_out stays 0xA5, no data_vld.
3. frame_start then first bit_vld with sampled_bit=1 -> strt_glitch one cycle, glitch_cnt=1, busy=0. A following valid 0x3C frame is received correctly.
4. STOP_BITS=2, data 0x5A, stop bits 1,0 -> stp_err pulse, stp_err_cnt=1, no data_vld. Same frame with stops 1,1 -> data_vld, data_out=0x5A.
5. ERR_CNT_W=2: five glitch frames -> glitch_cnt=3 (saturated). clr_cnt coincident with a sixth glitch -> glitch_cnt=0.
6. Assert Rst after 4 data bits, release, send frame 0xFF with par_en=1, par_typ=1 (parity bit 1) -> no pulses during reset, then data_vld with data_out=0xFF.
